sa_cache_lease_policy_controller: RTL and testbench

Lease-based replacement controller for a set-associative cache, generalising the fully-associative lease controller to N_SETS x N_WAYS.
- Holds one lease counter per line and decays them on every serviced access.
- On a miss, picks the victim way within the addressed set: per-set cold-start fill first, then an expired way, then a fallback way.
- Sits beside the cache controller. It receives the selected lease from the external lease lookup table and probability stage, and returns the victim way plus metric flags.

---
 rtl/sa_cache_lease_policy_controller.sv | 210 +++++++++++++++++++++
 tb/tb_sa_cache_lease_policy_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_cache_lease_policy_controller.sv
// sa_cache_lease_policy_controller
// Lease-based victim selection for an N_SETS x N_WAYS set-associative cache.
// Every line carries a lease counter that decays on each serviced access; on
// a miss the victim within the addressed set is chosen by cold fill first,
// then the lowest expired way, then a fallback way.
// Optional build macro: LEASE_MIN_EVICT_EN -- fallback picks the way with the
// smallest remaining lease instead of the 9-bit LFSR (x^9 + x^5 + 1).
module sa_cache_lease_policy_controller #(
   parameter int unsigned N_SETS    = 16,
   parameter int unsigned N_WAYS    = 8,
   parameter int unsigned LEASE_BW  = 10,
   parameter logic [8:0]  LFSR_SEED = 9'h155,
   localparam int unsigned SET_W    = (N_SETS > 1) ? $clog2(N_SETS) : 1,
   localparam int unsigned WAY_W    = $clog2(N_WAYS),
   localparam int unsigned N_LINES  = N_SETS * N_WAYS
) (
   input  logic                clock_i,
   input  logic                resetn_i,
   input  logic                con_wren_i,
   input  logic [31:0]         con_data_i,
   input  logic [SET_W-1:0]    set_i,
   input  logic [WAY_W-1:0]    way_i,
   input  logic                hit_i,
   input  logic                miss_i,
   input  logic [LEASE_BW-1:0] lease_i,
   input  logic                lease_hit_i,
   output logic                done_o,
   output logic [WAY_W-1:0]    way_o,
   output logic                swap_o,
   output logic                expired_o,
   output logic                expired_multi_o,
   output logic                default_o,
   output logic [N_LINES-1:0]  eviction_bits_o
);

   localparam int unsigned    LINE_W   = $clog2(N_LINES);
   localparam logic [SET_W-1:0] SET_MASK = SET_W'(N_SETS - 1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_REPLACE = 1'b1
   } state_t;

   state_t                         r_state;
   logic [LEASE_BW-1:0]            r_lease [N_LINES];
   logic [LEASE_BW-1:0]            r_default;
   logic [LEASE_BW-1:0]            r_sav_lease;
   logic [SET_W-1:0]               r_sav_set;
   logic                           r_follow;
   logic [N_SETS-1:0][WAY_W-1:0]   r_fill;
   logic [N_SETS-1:0]              r_full;
   logic [8:0]                     r_lfsr;

   logic [SET_W-1:0]               w_set_in;
   logic [LEASE_BW-1:0]            w_eff;
   logic                           w_idle_miss;
   logic                           w_idle_hit;
   logic                           w_do_dec;
   logic                           w_wr_en;
   logic [LINE_W-1:0]              w_wr_line;
   logic [LEASE_BW-1:0]            w_wr_val;
   logic [LINE_W-1:0]              w_sav_base;
   logic [LINE_W-1:0]              w_hit_base;
   logic                           w_any_exp;
   logic [WAY_W-1:0]               w_lo_exp;
   logic [WAY_W-1:0]               w_hi_exp;
   logic [LEASE_BW-1:0]            w_cur;
   logic [8:0]                     w_lfsr_next;
   logic                           w_unused_con;
`ifdef LEASE_MIN_EVICT_EN
   logic [WAY_W-1:0]               w_min_way;
   logic [LEASE_BW-1:0]            w_min_val;
`endif

   // Only the low LEASE_BW config bits carry the default lease.
   assign w_unused_con = ^con_data_i[31:LEASE_BW];

   assign w_set_in    = set_i & SET_MASK;
   assign w_eff       = lease_hit_i ? lease_i : r_default;
   assign w_idle_miss = (r_state == S_IDLE) && miss_i;
   assign w_idle_hit  = (r_state == S_IDLE) && hit_i && !miss_i;
   assign w_sav_base  = LINE_W'(r_sav_set) << WAY_W;
   assign w_hit_base  = LINE_W'(w_set_in) << WAY_W;
   assign w_lfsr_next = {r_lfsr[7:0], r_lfsr[8] ^ r_lfsr[4]};

   // A follow-up hit installs the saved lease without decay; a plain hit
   // decays everything and renews the referenced line with the effective lease.
   assign w_do_dec  = w_idle_miss || (w_idle_hit && !r_follow);
   assign w_wr_en   = w_idle_hit;
   assign w_wr_line = r_follow ? (w_sav_base | LINE_W'(way_i))
                               : (w_hit_base | LINE_W'(way_i));
   assign w_wr_val  = r_follow ? r_sav_lease : w_eff;

   // Per-line lease counters: renewal takes priority over saturating decay.
   for (genvar g = 0; g < N_LINES; g++) begin : g_line
      always_ff @(posedge clock_i or negedge resetn_i) begin
         if (!resetn_i) begin
            r_lease[g] <= '0;
         end else if (w_wr_en && (w_wr_line == LINE_W'(g))) begin
            r_lease[g] <= w_wr_val;
         end else if (w_do_dec && (r_lease[g] != '0)) begin
            r_lease[g] <= r_lease[g] - LEASE_BW'(1);
         end
      end
      assign eviction_bits_o[g] = (r_lease[g] == '0);
   end

   // Scan the saved set for expired ways (lowest/highest) and the minimum lease.
   always_comb begin
      w_any_exp = 1'b0;
      w_lo_exp  = '0;
      w_hi_exp  = '0;
      w_cur     = '0;
`ifdef LEASE_MIN_EVICT_EN
      w_min_way = '0;
      w_min_val = '1;
`endif
      for (int unsigned w = 0; w < N_WAYS; w++) begin
         w_cur = r_lease[w_sav_base | LINE_W'(w)];
         if (w_cur == '0) begin
            if (!w_any_exp) begin
               w_lo_exp = WAY_W'(w);
            end
            w_hi_exp  = WAY_W'(w);
            w_any_exp = 1'b1;
         end
`ifdef LEASE_MIN_EVICT_EN
         if ((w == 0) || (w_cur < w_min_val)) begin
            w_min_val = w_cur;
            w_min_way = WAY_W'(w);
         end
`endif
      end
   end

   // Control FSM: miss handling, one-cycle victim selection, registered outputs.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state         <= S_IDLE;
         r_default       <= '0;
         r_sav_lease     <= '0;
         r_sav_set       <= '0;
         r_follow        <= 1'b0;
         r_fill          <= '0;
         r_full          <= '0;
         r_lfsr          <= LFSR_SEED;
         done_o          <= 1'b0;
         way_o           <= '0;
         swap_o          <= 1'b0;
         expired_o       <= 1'b0;
         expired_multi_o <= 1'b0;
         default_o       <= 1'b0;
      end else begin
         expired_o       <= 1'b0;
         expired_multi_o <= 1'b0;
         default_o       <= 1'b0;
         if (con_wren_i) begin
            r_default <= con_data_i[LEASE_BW-1:0];
         end
         unique case (r_state)
            S_IDLE: begin
               if (miss_i) begin
                  default_o <= !lease_hit_i;
                  if (w_eff != '0) begin
                     r_sav_lease <= w_eff;
                     r_sav_set   <= w_set_in;
                     r_follow    <= 1'b1;
                     done_o      <= 1'b0;
                     swap_o      <= 1'b1;
                     r_state     <= S_REPLACE;
                  end else begin
                     done_o <= 1'b1;
                     swap_o <= 1'b0;
                  end
               end else if (hit_i) begin
                  if (r_follow) begin
                     r_follow <= 1'b0;
                  end else begin
                     default_o <= !lease_hit_i;
                  end
               end
            end
            S_REPLACE: begin
               if (!r_full[r_sav_set]) begin
                  way_o             <= r_fill[r_sav_set];
                  r_fill[r_sav_set] <= r_fill[r_sav_set] + WAY_W'(1);
                  if (r_fill[r_sav_set] == WAY_W'(N_WAYS - 1)) begin
                     r_full[r_sav_set] <= 1'b1;
                  end
               end else if (w_any_exp) begin
                  way_o           <= w_lo_exp;
                  expired_o       <= 1'b1;
                  expired_multi_o <= (w_lo_exp != w_hi_exp);
               end else begin
`ifdef LEASE_MIN_EVICT_EN
                  way_o  <= w_min_way;
`else
                  way_o  <= r_lfsr[WAY_W:1];
                  r_lfsr <= w_lfsr_next;
`endif
               end
               done_o  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sa_cache_lease_policy_controller.sv
// Self-checking bench for sa_cache_lease_policy_controller (4 sets x 4 ways).
module tb_sa_cache_lease_policy_controller;

   localparam int NS = 4;
   localparam int NW = 4;
   localparam int LB = 10;
   localparam int NL = NS * NW;
   localparam int SW = $clog2(NS);
   localparam int WW = $clog2(NW);

   logic          clock_i = 1'b0;
   logic          resetn_i = 1'b0;
   logic          con_wren_i = 1'b0;
   logic [31:0]   con_data_i = '0;
   logic [SW-1:0] set_i = '0;
   logic [WW-1:0] way_i = '0;
   logic          hit_i = 1'b0;
   logic          miss_i = 1'b0;
   logic [LB-1:0] lease_i = '0;
   logic          lease_hit_i = 1'b0;
   logic          done_o;
   logic [WW-1:0] way_o;
   logic          swap_o;
   logic          expired_o;
   logic          expired_multi_o;
   logic          default_o;
   logic [NL-1:0] eviction_bits_o;

   sa_cache_lease_policy_controller #(
      .N_SETS   (NS),
      .N_WAYS   (NW),
      .LEASE_BW (LB),
      .LFSR_SEED(9'h155)
   ) dut (
      .clock_i        (clock_i),
      .resetn_i       (resetn_i),
      .con_wren_i     (con_wren_i),
      .con_data_i     (con_data_i),
      .set_i          (set_i),
      .way_i          (way_i),
      .hit_i          (hit_i),
      .miss_i         (miss_i),
      .lease_i        (lease_i),
      .lease_hit_i    (lease_hit_i),
      .done_o         (done_o),
      .way_o          (way_o),
      .swap_o         (swap_o),
      .expired_o      (expired_o),
      .expired_multi_o(expired_multi_o),
      .default_o      (default_o),
      .eviction_bits_o(eviction_bits_o)
   );

   always #5 clock_i = ~clock_i;

   int total = 0;
   int bad   = 0;

   // reference model: plain integers per line, fill counts per set
   int m_lease [NL];
   int m_fill  [NS];
   int m_def;
   int m_follow;
   int m_sav_lease;
   int m_sav_set;
   int m_lfsr;
   int e_done;
   int e_swap;
   int e_way;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask

   task automatic model_reset();
      foreach (m_lease[l]) m_lease[l] = 0;
      foreach (m_fill[s]) m_fill[s] = 0;
      m_def = 0; m_follow = 0; m_sav_lease = 0; m_sav_set = 0;
      m_lfsr = 'h155;
      e_done = 0; e_swap = 0; e_way = 0;
   endtask

   task automatic decay();
      foreach (m_lease[l]) if (m_lease[l] > 0) m_lease[l]--;
   endtask

   task automatic check_outputs(input string tag, input int ee, input int em, input int ed);
      logic [NL-1:0] ev;
      for (int l = 0; l < NL; l++) ev[l] = (m_lease[l] == 0);
      chk({tag, ".done"},  64'(done_o),          64'(e_done));
      chk({tag, ".swap"},  64'(swap_o),          64'(e_swap));
      chk({tag, ".way"},   64'(way_o),           64'(e_way));
      chk({tag, ".exp"},   64'(expired_o),       64'(ee));
      chk({tag, ".multi"}, 64'(expired_multi_o), 64'(em));
      chk({tag, ".dflt"},  64'(default_o),       64'(ed));
      chk({tag, ".evict"}, 64'(eviction_bits_o), 64'(ev));
   endtask

   task automatic clear_strobes();
      miss_i = 1'b0; hit_i = 1'b0; con_wren_i = 1'b0;
   endtask

   // REPLACE cycle: optional noise on the ignored strobes plus a config write
   task automatic replace_step(input bit noise);
      bit nwr;
      int nd;
      int base;
      int q[$];
      int ee;
      int em;
      nwr = 1'b0; nd = 0;
      if (noise) begin
         miss_i = 1'($urandom); hit_i = 1'($urandom);
         set_i = SW'($urandom); way_i = WW'($urandom);
         lease_i = LB'($urandom); lease_hit_i = 1'($urandom);
         nwr = ($urandom_range(0, 2) == 0);
         nd = $urandom_range(0, 6);
         con_wren_i = nwr; con_data_i = 32'(nd);
      end
      tick();
      clear_strobes();
      base = m_sav_set * NW;
      for (int w = 0; w < NW; w++) if (m_lease[base + w] == 0) q.push_back(w);
      ee = 0; em = 0;
      if (m_fill[m_sav_set] < NW) begin
         e_way = m_fill[m_sav_set];
         m_fill[m_sav_set]++;
      end else if (q.size() > 0) begin
         e_way = q[0]; ee = 1; em = (q.size() > 1) ? 1 : 0;
      end else begin
`ifdef LEASE_MIN_EVICT_EN
         e_way = 0;
         for (int w = 1; w < NW; w++) if (m_lease[base + w] < m_lease[base + e_way]) e_way = w;
`else
         e_way = (m_lfsr >> 1) % NW;
         m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 8) ^ (m_lfsr >> 4)) & 1)) & 'h1FF;
`endif
      end
      e_done = 1;
      if (nwr) m_def = nd;
      check_outputs("rep", ee, em, 0);
   endtask

   task automatic access(input bit is_miss, input bit is_hit, input int set, input int way,
                         input int lease, input bit lh, input bit wr, input int wdata,
                         input bit noise);
      int eff;
      int defp;
      bit repl;
      miss_i = is_miss; hit_i = is_hit;
      set_i = SW'(set); way_i = WW'(way);
      lease_i = LB'(lease); lease_hit_i = lh;
      con_wren_i = wr;
      con_data_i = ($urandom & ~((32'd1 << LB) - 32'd1)) | 32'(wdata);
      tick();
      clear_strobes();
      eff = lh ? lease : m_def;
      defp = 0; repl = 1'b0;
      if (is_miss) begin
         defp = lh ? 0 : 1;
         decay();
         if (eff != 0) begin
            m_sav_lease = eff; m_sav_set = set; m_follow = 1;
            e_done = 0; e_swap = 1; repl = 1'b1;
         end else begin
            e_done = 1; e_swap = 0;
         end
      end else if (is_hit) begin
         if (m_follow != 0) begin
            m_lease[m_sav_set * NW + way] = m_sav_lease;
            m_follow = 0;
         end else begin
            defp = lh ? 0 : 1;
            decay();
            m_lease[set * NW + way] = eff;
         end
      end
      if (wr) m_def = wdata;
      check_outputs("acc", 0, 0, defp);
      if (repl) replace_step(noise);
   endtask

   task automatic fill_set(input int set, input int l0, input int l1, input int l2, input int l3);
      int ls[4];
      ls = '{l0, l1, l2, l3};
      for (int w = 0; w < NW; w++) begin
         access(1, 0, set, 0, ls[w], 1, 0, 0, 0);
         chk("fill.way", 64'(way_o), 64'(w));
         access(0, 1, set, w, 0, 1, 0, 0, 0);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clock_i);
      #1;
      check_outputs("reset", 0, 0, 0);
      resetn_i = 1'b1;

      // cold fill of set 2 with explicit lease 3
      access(0, 0, 0, 0, 0, 0, 1, 5, 0);
      for (int i = 0; i < NW; i++) begin
         access(1, 0, 2, 0, 3, 1, 0, 0, 0);
         chk("t1.way", 64'(way_o), 64'(i));
         chk("t1.swap", 64'(swap_o), 64'd1);
      end

      // default lease of 0: serviced without allocation
      access(0, 0, 0, 0, 0, 0, 1, 0, 0);
      access(1, 0, 3, 0, 0, 0, 0, 0, 0);
      chk("t2.done", 64'(done_o), 64'd1);
      chk("t2.swap", 64'(swap_o), 64'd0);
      chk("t2.dflt", 64'(default_o), 64'd1);
      access(0, 0, 0, 0, 0, 0, 1, 5, 0);

      // set 1: ways 1 and 3 expire, then a miss picks the lowest
      fill_set(1, 20, 3, 20, 3);
      repeat (3) access(0, 1, 0, 0, 0, 0, 0, 0, 0);
      access(1, 0, 1, 0, 4, 1, 0, 0, 0);
      chk("t3.way", 64'(way_o), 64'd1);
      chk("t3.exp", 64'(expired_o), 64'd1);
      chk("t3.multi", 64'(expired_multi_o), 64'd1);

      // set 3 full, nothing expired: fallback way
      fill_set(3, 40, 30, 50, 30);
      access(1, 0, 3, 0, 4, 1, 0, 0, 0);
`ifdef LEASE_MIN_EVICT_EN
      chk("t4.way", 64'(way_o), 64'd1);
`else
      chk("t4.way", 64'(way_o), 64'd2);
`endif

      // follow-up hit installs the saved lease
      access(1, 0, 0, 0, 6, 1, 0, 0, 0);
      access(0, 1, 0, 2, 0, 1, 0, 0, 0);

      // config write together with a miss uses the old default
      access(1, 0, 0, 0, 0, 0, 1, 3, 0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         int r;
         r = $urandom_range(0, 9);
         access(r < 4, (r >= 3) && (r < 9), $urandom_range(0, NS - 1), $urandom_range(0, NW - 1),
                $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      end

      // asynchronous reset in the middle of REPLACE
      miss_i = 1'b1; set_i = '0; lease_i = LB'(5); lease_hit_i = 1'b1;
      tick();
      clear_strobes();
      chk("mid.swap", 64'(swap_o), 64'd1);
      chk("mid.done", 64'(done_o), 64'd0);
      #2;
      resetn_i = 1'b0;
      #1;
      model_reset();
      check_outputs("midrst", 0, 0, 0);
      tick();
      resetn_i = 1'b1;
      access(1, 0, 0, 0, 5, 1, 0, 0, 0);
      chk("postrst.way", 64'(way_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
